// File: rtl/a8_bus_capture.sv
// A8 bus capture: samples one address/R-W/data record per A8 cycle, filters it against an
// address window and queues matches in a FWFT FIFO. Optional macro: A8_BUS_CAPTURE_TIMESTAMP_EN.
module a8_bus_capture #(
    parameter logic [15:0] WIN_BASE = 16'hD500,
    parameter logic [15:0] WIN_MASK = 16'hFF00,
    parameter int unsigned DEPTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a8_addr_strobe,
    input  logic                     a8_write_strobe,
    input  logic                     a8_read_strobe,
    input  logic                     a8_clk_falling,
    input  logic [15:0]              a8_addr,
    input  logic                     a8_rw_n,
    input  logic [7:0]               a8_data,
    output logic                     txn_valid,
    input  logic                     txn_ready,
    output logic [15:0]              txn_addr,
    output logic [7:0]               txn_data,
    output logic                     txn_write,
    output logic [15:0]              txn_stamp,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    input  logic                     overflow_clr,
    output logic [7:0]               abort_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("a8_bus_capture: DEPTH must be a power of two in 2..64");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [15:0]     r_addr;
    logic            r_rw_n;
    logic            w_in_window;
    logic            w_data_hit;
    logic            w_push;
    logic            w_abort;

    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_overflow;
    logic [7:0]      r_abort_count;
    logic            w_full;
    logic            w_pop;
    logic            w_push_ok;

    logic [15:0]     r_mem_addr  [DEPTH];
    logic [7:0]      r_mem_data  [DEPTH];
    logic            r_mem_write [DEPTH];

    // The window compare always looks at the live bus; it only matters on an address strobe.
    assign w_in_window = ((a8_addr & WIN_MASK) == (WIN_BASE & WIN_MASK));
    assign w_data_hit  = r_rw_n ? a8_read_strobe : a8_write_strobe;

    // ------------------------------------------------------------------
    // Cycle-tracking FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples
        // the pre-edge values of its neighbours, independent of block ordering.
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Priority inside a state: address strobe (restart) > clk falling > data strobe.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_abort     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (a8_addr_strobe) begin
                    w_state_nxt = w_in_window ? S_ARMED : S_DONE;
                end
            end
            S_ARMED: begin
                if (a8_addr_strobe) begin
                    w_abort     = 1'b1;
                    w_state_nxt = w_in_window ? S_ARMED : S_DONE;
                end else if (a8_clk_falling) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_data_hit) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (a8_addr_strobe) begin
                    w_state_nxt = w_in_window ? S_ARMED : S_DONE;
                end else if (a8_clk_falling) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_rw_n <= 1'b0;
        end else if (a8_addr_strobe) begin
            r_addr <= a8_addr;
            r_rw_n <= a8_rw_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_abort_count <= '0;
        end else if (w_abort && r_abort_count != 8'hFF) begin
            r_abort_count <= r_abort_count + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // FWFT FIFO
    // ------------------------------------------------------------------
    assign w_full    = (r_count == FULL_COUNT);
    assign w_pop     = txn_valid && txn_ready;
    assign w_push_ok = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push_ok) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // A set from a dropped push wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_push && !w_push_ok) begin
            r_overflow <= 1'b1;
        end else if (overflow_clr) begin
            r_overflow <= 1'b0;
        end
    end

    // NOTE: the storage array has no reset; an entry is only observed after it has
    // been written, and the head fields are masked to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem_addr[r_wr_ptr]  <= r_addr;
            r_mem_data[r_wr_ptr]  <= a8_data;
            r_mem_write[r_wr_ptr] <= ~r_rw_n;
        end
    end

`ifdef A8_BUS_CAPTURE_TIMESTAMP_EN
    logic [15:0] r_stamp;
    logic [15:0] r_mem_stamp [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stamp <= '0;
        end else if (a8_clk_falling) begin
            r_stamp <= r_stamp + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem_stamp[r_wr_ptr] <= r_stamp;
        end
    end

    assign txn_stamp = txn_valid ? r_mem_stamp[r_rd_ptr] : 16'd0;
`else
    assign txn_stamp = 16'd0;
`endif

    assign txn_valid   = (r_count != '0);
    assign txn_addr    = txn_valid ? r_mem_addr[r_rd_ptr]  : 16'd0;
    assign txn_data    = txn_valid ? r_mem_data[r_rd_ptr]  : 8'd0;
    assign txn_write   = txn_valid ? r_mem_write[r_rd_ptr] : 1'b0;
    assign fifo_count  = r_count;
    assign overflow    = r_overflow;
    assign abort_count = r_abort_count;

endmodule

// File: tb/tb_a8_bus_capture.sv
// Directed, table-driven bench for a8_bus_capture (DEPTH = 8, default window $D5xx).
module tb_a8_bus_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        a8_addr_strobe, a8_write_strobe, a8_read_strobe, a8_clk_falling;
    logic [15:0] a8_addr;
    logic        a8_rw_n;
    logic [7:0]  a8_data;
    logic        txn_valid, txn_ready;
    logic [15:0] txn_addr;
    logic [7:0]  txn_data;
    logic        txn_write;
    logic [15:0] txn_stamp;
    logic [3:0]  fifo_count;
    logic        overflow, overflow_clr;
    logic [7:0]  abort_count;

    int n_checks = 0;
    int n_fail   = 0;

    a8_bus_capture #(.WIN_BASE(16'hD500), .WIN_MASK(16'hFF00), .DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .a8_addr_strobe(a8_addr_strobe), .a8_write_strobe(a8_write_strobe),
        .a8_read_strobe(a8_read_strobe), .a8_clk_falling(a8_clk_falling),
        .a8_addr(a8_addr), .a8_rw_n(a8_rw_n), .a8_data(a8_data),
        .txn_valid(txn_valid), .txn_ready(txn_ready),
        .txn_addr(txn_addr), .txn_data(txn_data), .txn_write(txn_write),
        .txn_stamp(txn_stamp), .fifo_count(fifo_count),
        .overflow(overflow), .overflow_clr(overflow_clr), .abort_count(abort_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // All helpers start and end at posedge+1.
    task automatic drive(input logic as, input logic ws, input logic rs, input logic cf);
        a8_addr_strobe  = as;
        a8_write_strobe = ws;
        a8_read_strobe  = rs;
        a8_clk_falling  = cf;
        @(posedge clk); #1;
        a8_addr_strobe  = 1'b0;
        a8_write_strobe = 1'b0;
        a8_read_strobe  = 1'b0;
        a8_clk_falling  = 1'b0;
    endtask

    // kind: 0 = no data strobe, 1 = write strobe, 2 = read strobe
    task automatic do_cycle(input logic [15:0] addr, input logic rw_n, input logic [7:0] data,
                            input int kind);
        a8_addr = addr;
        a8_rw_n = rw_n;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        a8_data = data;
        if (kind == 1) drive(1'b0, 1'b1, 1'b0, 1'b0);
        else if (kind == 2) drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic pop_one();
        txn_ready = 1'b1;
        @(posedge clk); #1;
        txn_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a8_addr_strobe = 1'b0; a8_write_strobe = 1'b0;
        a8_read_strobe = 1'b0; a8_clk_falling  = 1'b0;
        a8_addr = '0; a8_rw_n = 1'b0; a8_data = '0;
        txn_ready = 1'b0; overflow_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [15:0] addr;
        logic        rw_n;
        logic [7:0]  data;
        int          kind;
        logic        exp_push;
        int          exp_count;
        int          exp_abort;
    } vec_t;

    vec_t vecs [8];
    logic [15:0] exp_addr_q [8];
    logic [7:0]  exp_data_q [8];

    initial begin
        vecs[0] = '{16'hD510, 1'b0, 8'h5A, 1, 1'b1, 1, 0};
        vecs[1] = '{16'hD5FF, 1'b1, 8'hC3, 2, 1'b1, 2, 0};
        vecs[2] = '{16'hD600, 1'b0, 8'h11, 1, 1'b0, 2, 0};
        vecs[3] = '{16'hD520, 1'b0, 8'h22, 2, 1'b0, 2, 1};
        vecs[4] = '{16'hD4FF, 1'b1, 8'h33, 2, 1'b0, 2, 1};
        vecs[5] = '{16'hD500, 1'b1, 8'h44, 1, 1'b0, 2, 2};
        vecs[6] = '{16'hD580, 1'b0, 8'h99, 0, 1'b0, 2, 3};
        vecs[7] = '{16'hD501, 1'b1, 8'h3C, 2, 1'b1, 3, 3};

        // Reset state
        do_reset();
        check("rst_valid", 32'(txn_valid), 0);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_abort", 32'(abort_count), 0);
        check("rst_addr", 32'(txn_addr), 0);
        check("rst_data", 32'(txn_data), 0);
        check("rst_write", 32'(txn_write), 0);
        check("rst_stamp", 32'(txn_stamp), 0);

        // Write latency: head appears one clk after the write strobe
        a8_addr = 16'hD510; a8_rw_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("lat_valid_before", 32'(txn_valid), 0);
        a8_data = 8'h5A;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("lat_valid", 32'(txn_valid), 1);
        check("lat_addr", 32'(txn_addr), 32'hD510);
        check("lat_data", 32'(txn_data), 32'h5A);
        check("lat_write", 32'(txn_write), 1);
        check("lat_count", 32'(fifo_count), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("lat_hold_addr", 32'(txn_addr), 32'hD510);

        // Table of A8 cycles with the consumer stalled
        do_reset();
        for (int i = 0; i < 8; i++) begin
            do_cycle(vecs[i].addr, vecs[i].rw_n, vecs[i].data, vecs[i].kind);
            check($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d_abort", i), 32'(abort_count), 32'(vecs[i].exp_abort));
        end
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].exp_push) begin
                check($sformatf("drain%0d_valid", i), 32'(txn_valid), 1);
                check($sformatf("drain%0d_addr", i), 32'(txn_addr), 32'(vecs[i].addr));
                check($sformatf("drain%0d_data", i), 32'(txn_data), 32'(vecs[i].data));
                check($sformatf("drain%0d_write", i), 32'(txn_write), 32'(!vecs[i].rw_n));
                pop_one();
            end
        end
        check("drain_empty", 32'(txn_valid), 0);

        // Aborts, simultaneous strobes and restarts
        do_reset();
        a8_addr = 16'hD520; a8_rw_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("abort_one", 32'(abort_count), 1);
        check("abort_no_push", 32'(fifo_count), 0);
        a8_addr = 16'hD540;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        check("fall_prio_abort", 32'(abort_count), 2);
        check("fall_prio_count", 32'(fifo_count), 0);
        a8_addr = 16'hD550;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        a8_addr = 16'hD560; a8_data = 8'h66;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("restart_abort", 32'(abort_count), 3);
        check("restart_count", 32'(fifo_count), 1);
        check("restart_addr", 32'(txn_addr), 32'hD560);
        a8_addr = 16'hD570;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("done_restart_abort", 32'(abort_count), 3);
        check("done_restart_count", 32'(fifo_count), 2);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("idle_stray_strobe", 32'(fifo_count), 2);
        a8_addr = 16'hD520;
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 1'b0, 1'b1);
        end
        check("abort_saturate", 32'(abort_count), 255);

        // Overflow and push-with-pop when full
        do_reset();
        for (int i = 0; i < 9; i++) begin
            do_cycle(16'hD500 + 16'(i), 1'b0, 8'(i), 1);
        end
        check("full_count", 32'(fifo_count), 8);
        check("full_overflow", 32'(overflow), 1);
        overflow_clr = 1'b1;
        @(posedge clk); #1;
        overflow_clr = 1'b0;
        check("ovf_cleared", 32'(overflow), 0);
        a8_addr = 16'hD5A0; a8_rw_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        a8_data = 8'hAA; txn_ready = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        txn_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("pushpop_count", 32'(fifo_count), 8);
        check("pushpop_overflow", 32'(overflow), 0);
        check("pushpop_head", 32'(txn_addr), 32'hD501);
        do_cycle(16'hD5B0, 1'b0, 8'hBB, 1);
        check("reject_overflow", 32'(overflow), 1);
        check("reject_count", 32'(fifo_count), 8);
        a8_addr = 16'hD5C0;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        overflow_clr = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        overflow_clr = 1'b0;
        check("set_beats_clr", 32'(overflow), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        overflow_clr = 1'b1;
        @(posedge clk); #1;
        overflow_clr = 1'b0;
        check("clr_alone", 32'(overflow), 0);
        for (int i = 0; i < 7; i++) begin
            exp_addr_q[i] = 16'hD501 + 16'(i);
            exp_data_q[i] = 8'(i + 1);
        end
        exp_addr_q[7] = 16'hD5A0;
        exp_data_q[7] = 8'hAA;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ovf_drain%0d_addr", i), 32'(txn_addr), 32'(exp_addr_q[i]));
            check($sformatf("ovf_drain%0d_data", i), 32'(txn_data), 32'(exp_data_q[i]));
            pop_one();
        end
        check("ovf_drain_count", 32'(fifo_count), 0);

        // Reset between address strobe and write strobe
        do_reset();
        a8_addr = 16'hD530; a8_rw_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        a8_data = 8'h11;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("midrst_count", 32'(fifo_count), 0);
        check("midrst_valid", 32'(txn_valid), 0);
        do_cycle(16'hD531, 1'b0, 8'h42, 1);
        check("midrst_next_count", 32'(fifo_count), 1);
        check("midrst_next_addr", 32'(txn_addr), 32'hD531);
        check("midrst_next_data", 32'(txn_data), 32'h42);

        // Timestamp
        do_reset();
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b1);
        do_cycle(16'hD500, 1'b0, 8'h01, 1);
`ifdef A8_BUS_CAPTURE_TIMESTAMP_EN
        check("stamp", 32'(txn_stamp), 3);
`else
        check("stamp", 32'(txn_stamp), 0);
`endif
        check("stamp_valid", 32'(txn_valid), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
